// File: rtl/alu_pkg.sv
// alu_pkg: definitions shared by the ALU and its writeback stage.
// Holds the writeback FSM state type, the opcode-class encoding of wide
// (64-bit result) operations, and the default datapath widths.
package alu_pkg;

  localparam int ALU_DATA_W = 32;
  localparam int ALU_REG_AW = 5;

  // in_op[4:3] selects the opcode class; class 01 produces a 64-bit result
  localparam logic [1:0] OPC_CLASS_WIDE = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LO   = 2'b01,
    ST_HI   = 2'b10
  } wb_state_t;

  // True when the opcode belongs to the wide-result class
  function automatic logic is_wide_op(input logic [4:0] op);
    return (op[4:3] == OPC_CLASS_WIDE);
  endfunction

endpackage

// File: rtl/wb_retire_counter.sv
// wb_retire_counter: 32-bit wrapping counter of fully written-back results.
module wb_retire_counter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  output logic [31:0] count
);

  logic [31:0] count_r;

  assign count = count_r;

  // Count one per increment request; natural wrap from all-ones to zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= 32'd0;
    end else if (inc) begin
      count_r <= count_r + 32'd1;
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/alu_writeback.sv
// alu_writeback: writeback stage behind the ALU. Accepts one result per
// cycle, writes narrow results in one cycle and wide results as a low
// word to rd followed by a high word to rd+1. Writes to r0 are issued
// with the enable suppressed. Optional build macro ALU_WB_FLAGS_EN adds
// registered zero/negative flags (flag_z, flag_n).
module alu_writeback
  import alu_pkg::*;
#(
  parameter int DATA_W = ALU_DATA_W,
  parameter int REG_AW = ALU_REG_AW
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [4:0]          in_op,
  input  logic [REG_AW-1:0]   in_rd,
  input  logic [2*DATA_W-1:0] in_result,
  output logic                rf_we,
  output logic [REG_AW-1:0]   rf_waddr,
  output logic [DATA_W-1:0]   rf_wdata,
  output logic                fwd_valid,
  output logic [31:0]         retired
`ifdef ALU_WB_FLAGS_EN
  ,
  output logic                flag_z,
  output logic                flag_n
`endif
);

  wb_state_t           state_r;
  logic                held_wide_r;
  logic [REG_AW-1:0]   rd_r;
  logic [DATA_W-1:0]   hi_r;

  logic                in_ready_s;
  logic                wide_s;
  logic                transfer_s;
  logic                to_hi_s;
  logic                retire_s;
  logic [REG_AW-1:0]   rd_next_s;
  logic                unused_op_s;

  // Opcode low bits only matter to the ALU itself
  assign unused_op_s = ^in_op[2:0];

  // Ready depends on registered state only: blocked just in the wide LO cycle
  assign in_ready_s = (state_r != ST_LO) || !held_wide_r;
  assign in_ready   = in_ready_s;

  // Handshake decode, high-word sequencing and retire strobe
  always_comb begin
    wide_s     = is_wide_op(in_op);
    transfer_s = in_valid && in_ready_s;
    to_hi_s    = (state_r == ST_LO) && held_wide_r && !transfer_s;
    rd_next_s  = rd_r + {{(REG_AW-1){1'b0}}, 1'b1};
    if (transfer_s) begin
      retire_s = !wide_s;
    end else begin
      retire_s = to_hi_s;
    end
  end

  // FSM with registered write-port outputs; a new transfer always wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      held_wide_r <= 1'b0;
      rd_r        <= {REG_AW{1'b0}};
      hi_r        <= {DATA_W{1'b0}};
      rf_we       <= 1'b0;
      fwd_valid   <= 1'b0;
      rf_waddr    <= {REG_AW{1'b0}};
      rf_wdata    <= {DATA_W{1'b0}};
    end else if (transfer_s) begin
      state_r     <= ST_LO;
      held_wide_r <= wide_s;
      rd_r        <= in_rd;
      hi_r        <= in_result[2*DATA_W-1:DATA_W];
      rf_waddr    <= in_rd;
      rf_wdata    <= in_result[DATA_W-1:0];
      rf_we       <= (in_rd != {REG_AW{1'b0}});
      fwd_valid   <= (in_rd != {REG_AW{1'b0}});
    end else if (to_hi_s) begin
      state_r     <= ST_HI;
      rf_waddr    <= rd_next_s;
      rf_wdata    <= hi_r;
      rf_we       <= (rd_next_s != {REG_AW{1'b0}});
      fwd_valid   <= (rd_next_s != {REG_AW{1'b0}});
    end else begin
      state_r     <= ST_IDLE;
      rf_we       <= 1'b0;
      fwd_valid   <= 1'b0;
    end
  end

`ifdef ALU_WB_FLAGS_EN
  logic flag_z_s;
  logic flag_n_s;

  // Wide results flag over all 64 bits, narrow over the low word only
  always_comb begin
    if (wide_s) begin
      flag_z_s = (in_result == {(2*DATA_W){1'b0}});
      flag_n_s = in_result[2*DATA_W-1];
    end else begin
      flag_z_s = (in_result[DATA_W-1:0] == {DATA_W{1'b0}});
      flag_n_s = in_result[DATA_W-1];
    end
  end

  // Flags load with the low write and hold through HI and IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_z <= 1'b0;
      flag_n <= 1'b0;
    end else if (transfer_s) begin
      flag_z <= flag_z_s;
      flag_n <= flag_n_s;
    end else begin
      flag_z <= flag_z;
      flag_n <= flag_n;
    end
  end
`endif

  wb_retire_counter u_retire (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (retire_s),
    .count (retired)
  );

endmodule
